// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Width of a counter that runs 0..clks_per_bit-1.
    function automatic int baud_cnt_w(input int clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: counts clk cycles within a serial bit and flags the last one.
module baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = baud_cnt_w(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serialises each word as a UART frame.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd,
    output logic              fifo_re,
    output logic              tx,
    output logic              busy
);

    localparam int BIT_W = (DATA_W < 2) ? 1 : $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [BIT_W-1:0]  w_bit_cnt_nxt;
    logic              r_tx;
    logic              r_fifo_re;
    logic              r_busy;
    logic              w_tx_nxt;
    logic              w_re_nxt;
    logic              w_busy_nxt;
    logic              w_tick;
    logic              w_baud_clear;

    // Holding the timer cleared outside the serial states guarantees a fresh count on entry to START.
    assign w_baud_clear = (r_state == IDLE) || (r_state == REQ) || (r_state == LOAD);

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (w_baud_clear),
        .tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_fifo_re <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx      <= w_tx_nxt;
            r_fifo_re <= w_re_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tx_nxt      = 1'b1;
        w_re_nxt      = 1'b0;
        w_busy_nxt    = 1'b1;

        case (r_state)
            IDLE: begin
                if (en && !fifo_empty) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_shift_nxt   = fifo_rd;
                w_bit_cnt_nxt = '0;
                w_state_nxt   = START;
            end
            START: begin
                if (w_tick) begin
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                // The bit counter is reused to count stop bits.
                if (w_tick) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = (en && !fifo_empty) ? REQ : IDLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with the state.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
        w_re_nxt   = (w_state_nxt == REQ);
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign tx      = r_tx;
    assign fifo_re = r_fifo_re;
    assign busy    = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO models feed two DUTs (1 and 2 stop bits); tx is checked against an ideal frame model.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: one stop bit
    logic           en_a = 1'b0;
    logic           empty_a;
    logic [DW-1:0]  rd_a = '0;
    logic           re_a, tx_a, busy_a;
    logic [DW-1:0]  mem_a [0:63];
    logic [5:0]     wp_a = '0;
    logic [5:0]     rp_a = '0;

    // DUT B: two stop bits
    logic           en_b = 1'b0;
    logic           empty_b;
    logic [DW-1:0]  rd_b = '0;
    logic           re_b, tx_b, busy_b;
    logic [DW-1:0]  mem_b [0:63];
    logic [5:0]     wp_b = '0;
    logic [5:0]     rp_b = '0;

    int n_tests = 0;
    int n_fail  = 0;

    assign empty_a = (wp_a == rp_a);
    assign empty_b = (wp_b == rp_b);

    always @(posedge clk) begin
        if (re_a) begin
            rd_a <= mem_a[rp_a];
            rp_a <= rp_a + 6'd1;
        end
        if (re_b) begin
            rd_b <= mem_b[rp_b];
            rp_b <= rp_b + 6'd1;
        end
    end

    fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en_a),
        .fifo_empty(empty_a),
        .fifo_rd   (rd_a),
        .fifo_re   (re_a),
        .tx        (tx_a),
        .busy      (busy_a)
    );

    fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en_b),
        .fifo_empty(empty_b),
        .fifo_rd   (rd_b),
        .fifo_re   (re_b),
        .tx        (tx_b),
        .busy      (busy_b)
    );

    task automatic push_a(input logic [DW-1:0] w);
        mem_a[wp_a] = w;
        wp_a = wp_a + 6'd1;
    endtask

    task automatic push_b(input logic [DW-1:0] w);
        mem_b[wp_b] = w;
        wp_b = wp_b + 6'd1;
    endtask

    // Ideal line level t cycles after the start bit begins: start low, LSB-first data, then high.
    function automatic logic exp_tx(input logic [DW-1:0] w, input int t);
        int j;
        if (t < 0) return 1'b1;
        j = t / CPB;
        if (j == 0) return 1'b0;
        if (j <= DW) return w[j-1];
        return 1'b1;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (tx_a !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx_a); end
        n_tests++;
        if (re_a !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b want 0", re_a); end
        n_tests++;
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_tests++;
        if (tx_b !== 1'b1 || busy_b !== 1'b0 || re_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_b: got tx=%b busy=%b re=%b want 1/0/0", tx_b, busy_b, re_b);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_empty_idle();
        en_a = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_tests++;
            if (re_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_idle c=%0d: got re=%b tx=%b busy=%b want 0/1/0", c, re_a, tx_a, busy_a);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_single();
        logic [DW-1:0] w;
        w = 8'hA5;
        push_a(w);
        en_a = 1'b1;
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            n_tests++;
            if (re_a !== (c == 1)) begin n_fail++; $display("FAIL single_re c=%0d: got %b", c, re_a); end
            n_tests++;
            if (tx_a !== exp_tx(w, c - 3)) begin
                n_fail++; $display("FAIL single_tx c=%0d: got %b want %b", c, tx_a, exp_tx(w, c - 3));
            end
            n_tests++;
            if (busy_a !== (c <= 42)) begin n_fail++; $display("FAIL single_busy c=%0d: got %b", c, busy_a); end
        end
        en_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] words [0:6];
        int n, period, k, off, pulses;
        logic etx;
        n = 7;
        period = (1 + DW + 1) * CPB + 2;
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
        for (int i = 3; i < 7; i++) words[i] = 8'($urandom);
        for (int i = 0; i < n; i++) push_a(words[i]);
        pulses = 0;
        en_a = 1'b1;
        for (int c = 1; c <= n * period + 4; c++) begin
            @(negedge clk);
            k = (c - 1) / period;
            off = (c - 1) % period;
            etx = (k < n) ? exp_tx(words[k], off - 2) : 1'b1;
            if (re_a === 1'b1) pulses++;
            n_tests++;
            if (re_a !== (k < n && off == 0)) begin n_fail++; $display("FAIL b2b_re c=%0d: got %b", c, re_a); end
            n_tests++;
            if (tx_a !== etx) begin n_fail++; $display("FAIL b2b_tx c=%0d: got %b want %b", c, tx_a, etx); end
            n_tests++;
            if (busy_a !== (k < n)) begin n_fail++; $display("FAIL b2b_busy c=%0d: got %b", c, busy_a); end
        end
        n_tests++;
        if (pulses != n) begin n_fail++; $display("FAIL b2b_pulses: got %0d want %0d", pulses, n); end
        en_a = 1'b0;
    endtask

    // Leaves the second queued word in the FIFO; returned so the next test can expect it.
    task automatic test_en_drop(output logic [DW-1:0] left);
        logic [DW-1:0] w0;
        w0 = 8'($urandom);
        left = 8'($urandom);
        push_a(w0);
        push_a(left);
        en_a = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            n_tests++;
            if (re_a !== (c == 1)) begin n_fail++; $display("FAIL endrop_re c=%0d: got %b", c, re_a); end
            n_tests++;
            if (tx_a !== exp_tx(w0, c - 3)) begin
                n_fail++; $display("FAIL endrop_tx c=%0d: got %b want %b", c, tx_a, exp_tx(w0, c - 3));
            end
            n_tests++;
            if (busy_a !== (c <= 42)) begin n_fail++; $display("FAIL endrop_busy c=%0d: got %b", c, busy_a); end
            if (c == 15) en_a = 1'b0;
        end
        n_tests++;
        if (6'(wp_a - rp_a) !== 6'd1) begin
            n_fail++; $display("FAIL endrop_level: got %0d want 1", 6'(wp_a - rp_a));
        end
    endtask

    task automatic test_reset_mid(input logic [DW-1:0] w0);
        logic [DW-1:0] w1;
        w1 = 8'($urandom);
        push_a(w1);
        en_a = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            n_tests++;
            if (tx_a !== exp_tx(w0, c - 3)) begin
                n_fail++; $display("FAIL rstmid_pre_tx c=%0d: got %b want %b", c, tx_a, exp_tx(w0, c - 3));
            end
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || re_a !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_abort: got tx=%b busy=%b re=%b want 1/0/0", tx_a, busy_a, re_a);
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            n_tests++;
            if (re_a !== (c == 1)) begin n_fail++; $display("FAIL rstmid_re c=%0d: got %b", c, re_a); end
            n_tests++;
            if (tx_a !== exp_tx(w1, c - 3)) begin
                n_fail++; $display("FAIL rstmid_tx c=%0d: got %b want %b", c, tx_a, exp_tx(w1, c - 3));
            end
            n_tests++;
            if (busy_a !== (c <= 42)) begin n_fail++; $display("FAIL rstmid_busy c=%0d: got %b", c, busy_a); end
        end
        n_tests++;
        if (empty_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_drained: empty=%b want 1", empty_a); end
        en_a = 1'b0;
    endtask

    task automatic test_stop_bits2();
        logic [DW-1:0] words [0:2];
        int n, period, k, off;
        logic etx;
        n = 3;
        period = (1 + DW + 2) * CPB + 2;
        for (int i = 0; i < n; i++) begin
            words[i] = 8'($urandom);
            push_b(words[i]);
        end
        en_b = 1'b1;
        for (int c = 1; c <= n * period + 4; c++) begin
            @(negedge clk);
            k = (c - 1) / period;
            off = (c - 1) % period;
            etx = (k < n) ? exp_tx(words[k], off - 2) : 1'b1;
            n_tests++;
            if (re_b !== (k < n && off == 0)) begin n_fail++; $display("FAIL stop2_re c=%0d: got %b", c, re_b); end
            n_tests++;
            if (tx_b !== etx) begin n_fail++; $display("FAIL stop2_tx c=%0d: got %b want %b", c, tx_b, etx); end
            n_tests++;
            if (busy_b !== (k < n)) begin n_fail++; $display("FAIL stop2_busy c=%0d: got %b", c, busy_b); end
        end
        en_b = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] leftover;
        test_reset();
        test_empty_idle();
        test_single();
        test_back_to_back();
        test_en_drop(leftover);
        test_reset_mid(leftover);
        test_stop_bits2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
